// File: rtl/sam_video_address_if.sv
// Signal bundle between the VDG timing outputs, the video address generator
// and the RAM address multiplexer.
interface sam_video_address_if;
  logic        da0;
  logic        hsn;
  logic        fsn;
  logic        ag;
  logic [2:0]  gm;
  logic [6:0]  base;
  logic [15:0] addr;
  logic        fetch;
  logic [3:0]  row_rep;

  // Address generator side: consumes VDG timing and mode, drives the RAM address.
  modport slave (
    input  da0, hsn, fsn, ag, gm, base,
    output addr, fetch, row_rep
  );

  // VDG / mode-register side.
  modport master (
    output da0, hsn, fsn, ag, gm, base,
    input  addr, fetch, row_rep
  );
endinterface

// File: rtl/sam_video_address.sv
// Display-RAM address generator: turns VDG fetch/row/frame strobes into byte
// addresses, applying per-mode row repetition and row width.
module sam_video_address (
  input  logic                 clk,
  input  logic                 rst,
  sam_video_address_if.slave   bus
);

  logic        r_da0_s1, r_da0_s2;
  logic        r_hsn_s1, r_hsn_s2;
  logic        r_fsn_s1, r_fsn_s2;
  logic [3:0]  r_mode;
  logic [15:0] r_addr;
  logic [15:0] r_line_start;
  logic [5:0]  r_col;
  logic [3:0]  r_rep;
  logic        r_fetch;

  logic        w_da0_rise;
  logic        w_hsn_fall;
  logic        w_fsn_fall;
  logic [3:0]  w_div_m1;
  logic [5:0]  w_bytes;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_da0_s1 <= 1'b0;
      r_da0_s2 <= 1'b0;
      r_hsn_s1 <= 1'b1;
      r_hsn_s2 <= 1'b1;
      r_fsn_s1 <= 1'b1;
      r_fsn_s2 <= 1'b1;
    end else begin
      r_da0_s1 <= bus.da0;
      r_da0_s2 <= r_da0_s1;
      r_hsn_s1 <= bus.hsn;
      r_hsn_s2 <= r_hsn_s1;
      r_fsn_s1 <= bus.fsn;
      r_fsn_s2 <= r_fsn_s1;
    end
  end

  assign w_da0_rise = r_da0_s1 & ~r_da0_s2;
  assign w_hsn_fall = ~r_hsn_s1 & r_hsn_s2;
  assign w_fsn_fall = ~r_fsn_s1 & r_fsn_s2;

  // Geometry of the latched mode: repeat count minus one and bytes per row.
  always_comb begin
    w_div_m1 = 4'd11;
    w_bytes  = 6'd32;
    if (r_mode[3]) begin
      case (r_mode[2:0])
        3'd0, 3'd1: begin w_div_m1 = 4'd2; w_bytes = 6'd16; end
        3'd2:       begin w_div_m1 = 4'd2; w_bytes = 6'd32; end
        3'd3:       begin w_div_m1 = 4'd1; w_bytes = 6'd16; end
        3'd4:       begin w_div_m1 = 4'd1; w_bytes = 6'd32; end
        3'd5:       begin w_div_m1 = 4'd0; w_bytes = 6'd16; end
        default:    begin w_div_m1 = 4'd0; w_bytes = 6'd32; end
      endcase
    end
  end

  // Frame sync beats row sync beats fetch; a losing event is dropped outright.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode       <= 4'b0000;
      r_addr       <= 16'h0000;
      r_line_start <= 16'h0000;
      r_col        <= 6'd0;
      r_rep        <= 4'd0;
      r_fetch      <= 1'b0;
    end else begin
      r_fetch <= 1'b0;
      if (w_fsn_fall) begin
        r_mode       <= {bus.ag, bus.gm};
        r_addr       <= {bus.base, 9'b0};
        r_line_start <= {bus.base, 9'b0};
        r_col        <= 6'd0;
        r_rep        <= 4'd0;
      end else if (w_hsn_fall) begin
        r_col <= 6'd0;
        if (r_rep == w_div_m1) begin
          r_rep        <= 4'd0;
          r_line_start <= r_addr;
        end else begin
          r_rep  <= r_rep + 4'd1;
          r_addr <= r_line_start;
        end
      end else if (w_da0_rise && (r_col < w_bytes)) begin
        r_addr  <= r_addr + 16'd1;
        r_col   <= r_col + 6'd1;
        r_fetch <= 1'b1;
      end
    end
  end

  assign bus.addr    = r_addr;
  assign bus.fetch   = r_fetch;
  assign bus.row_rep = r_rep;

endmodule

// File: tb/tb_sam_video_address.sv
// Directed self-checking bench for sam_video_address with hand-computed
// addresses, repeat indices and fetch-strobe counts.
module tb_sam_video_address;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   fetchCount;
  int   fetchMark;

  sam_video_address_if bus ();

  sam_video_address dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.fetch === 1'b1) fetchCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulseDa0(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) bus.da0 = 1'b1;
      waitCycles(2);
      bus.da0 = 1'b0;
      waitCycles(1);
    end
    waitCycles(3);
  endtask

  task automatic pulseHsn();
    @(negedge clk) bus.hsn = 1'b0;
    waitCycles(2);
    bus.hsn = 1'b1;
    waitCycles(3);
  endtask

  task automatic pulseFsn();
    @(negedge clk) bus.fsn = 1'b0;
    waitCycles(2);
    bus.fsn = 1'b1;
    waitCycles(3);
  endtask

  task automatic applyStimulus(input logic ag, input logic [2:0] gm,
                               input logic [6:0] base);
    bus.ag   = ag;
    bus.gm   = gm;
    bus.base = base;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    fetchCount = 0;
    bus.da0    = 1'b0;
    bus.hsn    = 1'b1;
    bus.fsn    = 1'b1;
    applyStimulus(1'b1, 3'd6, 7'h00);
    rst = 1'b1;
    waitCycles(3);
    checkOutput("reset addr", bus.addr, 16'h0000);
    checkOutput("reset row_rep", bus.row_rep, 4'd0);
    checkOutput("reset fetch", bus.fetch, 1'b0);
    @(negedge clk) rst = 1'b0;

    // Frame start with exact two-clock latency
    applyStimulus(1'b1, 3'd6, 7'h02);
    @(negedge clk) bus.fsn = 1'b0;
    @(negedge clk);
    checkOutput("fsn latency 1 clk", bus.addr, 16'h0000);
    @(negedge clk);
    checkOutput("fsn latency 2 clk", bus.addr, 16'h0400);
    bus.fsn = 1'b1;
    waitCycles(3);
    checkOutput("frame row_rep", bus.row_rep, 4'd0);
    checkOutput("frame fetch", bus.fetch, 1'b0);

    // gm6 linear row
    fetchMark = fetchCount;
    pulseDa0(32);
    checkOutput("gm6 32 fetch addr", bus.addr, 16'h0420);
    checkOutput("gm6 fetch count", fetchCount - fetchMark, 32);
    pulseDa0(5);
    checkOutput("gm6 extra da0 addr", bus.addr, 16'h0420);
    checkOutput("gm6 extra da0 count", fetchCount - fetchMark, 32);
    pulseHsn();
    checkOutput("gm6 hsn addr", bus.addr, 16'h0420);
    checkOutput("gm6 hsn row_rep", bus.row_rep, 4'd0);

    // gm3 two-fold repeat
    applyStimulus(1'b1, 3'd3, 7'h02);
    pulseFsn();
    checkOutput("gm3 frame addr", bus.addr, 16'h0400);
    pulseDa0(16);
    checkOutput("gm3 row addr", bus.addr, 16'h0410);
    pulseHsn();
    checkOutput("gm3 hsn1 addr", bus.addr, 16'h0400);
    checkOutput("gm3 hsn1 row_rep", bus.row_rep, 4'd1);
    pulseDa0(16);
    pulseHsn();
    checkOutput("gm3 hsn2 addr", bus.addr, 16'h0410);
    checkOutput("gm3 hsn2 row_rep", bus.row_rep, 4'd0);

    // Alpha twelve-fold repeat
    applyStimulus(1'b0, 3'd0, 7'h02);
    pulseFsn();
    for (int r = 0; r < 12; r++) begin
      pulseDa0(32);
      pulseHsn();
      checkOutput($sformatf("alpha row %0d row_rep", r), bus.row_rep, (r + 1) % 12);
      checkOutput($sformatf("alpha row %0d addr", r), bus.addr,
                  (r < 11) ? 32'h0400 : 32'h0420);
    end

    // fsn and hsn falling together: frame reload only
    applyStimulus(1'b1, 3'd3, 7'h02);
    pulseFsn();
    pulseDa0(16);
    bus.base = 7'h03;
    @(negedge clk) begin bus.fsn = 1'b0; bus.hsn = 1'b0; end
    waitCycles(2);
    bus.fsn = 1'b1;
    bus.hsn = 1'b1;
    waitCycles(3);
    checkOutput("fsn+hsn addr", bus.addr, 16'h0600);
    checkOutput("fsn+hsn row_rep", bus.row_rep, 4'd0);

    // da0 rising with hsn falling: no increment
    applyStimulus(1'b1, 3'd6, 7'h02);
    pulseFsn();
    pulseDa0(3);
    checkOutput("pre-collision addr", bus.addr, 16'h0403);
    fetchMark = fetchCount;
    @(negedge clk) begin bus.da0 = 1'b1; bus.hsn = 1'b0; end
    waitCycles(2);
    bus.da0 = 1'b0;
    bus.hsn = 1'b1;
    waitCycles(3);
    checkOutput("da0+hsn addr", bus.addr, 16'h0403);
    checkOutput("da0+hsn fetch count", fetchCount - fetchMark, 0);

    // Address wrap from the top page
    applyStimulus(1'b1, 3'd6, 7'h7F);
    pulseFsn();
    checkOutput("top page addr", bus.addr, 16'hFE00);
    fetchMark = fetchCount;
    for (int r = 0; r < 16; r++) begin
      pulseDa0(32);
      pulseHsn();
    end
    checkOutput("wrap addr", bus.addr, 16'h0000);
    checkOutput("wrap fetch count", fetchCount - fetchMark, 512);

    // Mode change mid-frame is deferred to the next frame
    applyStimulus(1'b1, 3'd6, 7'h02);
    pulseFsn();
    bus.gm = 3'd0;
    pulseDa0(32);
    checkOutput("deferred mode addr", bus.addr, 16'h0420);
    pulseHsn();
    checkOutput("deferred mode row_rep", bus.row_rep, 4'd0);
    pulseFsn();
    pulseDa0(32);
    checkOutput("new mode width addr", bus.addr, 16'h0410);
    pulseHsn();
    checkOutput("new mode hsn addr", bus.addr, 16'h0400);
    checkOutput("new mode row_rep", bus.row_rep, 4'd1);

    // Reset mid-row aborts state
    pulseDa0(5);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    checkOutput("mid-row reset addr", bus.addr, 16'h0000);
    checkOutput("mid-row reset row_rep", bus.row_rep, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sam_video_address.md
# sam_video_address

Video address generator at the memory end of the display interface. It consumes the VDG's `da0` fetch clock, `hsn` row sync and `fsn` frame sync, and produces the 16-bit display-RAM address. It applies per-mode row repetition (÷1/÷2/÷3/÷12) and row width (16/32 bytes) so that the VDG only pulses `da0` and never tracks mode geometry. The block sits between the VDG timing outputs and the RAM address multiplexer.

## Interface
- No parameters.
- `clk` input 1 — system clock; all logic on rising edge.
- `rst` input 1 — synchronous, active-high reset.
- `da0` input 1 — VDG fetch strobe; each rising edge requests the next byte.
- `hsn` input 1 — VDG row sync, active low; falling edge = end of row.
- `fsn` input 1 — VDG frame sync, active low; falling edge = start of frame.
- `ag` input 1 — 0 = alpha/semigraphics, 1 = graphics.
- `gm` input 3 — graphics mode 0–7 (ignored when `ag`=0).
- `base` input 7 — display page; frame start address = `{base, 9'b0}`.
- `addr` output 16 — current display-RAM byte address.
- `fetch` output 1 — one-cycle strobe, high in the cycle `addr` has just advanced.
- `row_rep` output 4 — repeat index of the current source row (0 … div−1).

## Operation
- Input capture: `da0`, `hsn` and `fsn` each pass through a two-flop chain (s1, s2).
  - `da0_rise` = s1 & ~s2.
  - `hsn_fall` = ~s1 & s2.
  - `fsn_fall` = ~s1 & s2.
- Mode latch: `{ag, gm}` is latched into `mode_q` only on `fsn_fall`. A mid-frame change takes effect at the next frame. The decoded geometry is:
  - alpha (`ag`=0): div 12, 32 bytes.
  - gm0: div 3, 16 bytes. gm1: div 3, 16 bytes. gm2: div 3, 32 bytes.
  - gm3: div 2, 16 bytes. gm4: div 2, 32 bytes.
  - gm5: div 1, 16 bytes. gm6: div 1, 32 bytes. gm7: div 1, 32 bytes.
- Internal state:
  - `line_start[15:0]` — address of the first byte of the current source row.
  - `col[5:0]` — bytes fetched in the current row.
  - `rep[3:0]` — exported as `row_rep`.
- Event priority per cycle: `fsn_fall` > `hsn_fall` > `da0_rise`. A lower-priority event in the same cycle is discarded, not deferred.
- On `fsn_fall`:
  - `addr` = `line_start` = `{base, 9'b0}`, using the `base` value sampled that cycle.
  - `col` = 0, `rep` = 0.
  - Mode latched.
- On `hsn_fall`, `col` = 0, then one of:
  - If `rep` == div−1: `rep` = 0 and `line_start` = `addr`. The address continues into the next source row.
  - Else: `rep` += 1 and `addr` = `line_start`. The same source row repeats.
- On `da0_rise`:
  - If `col` < bytes: `addr` += 1 (mod 2^16, wraps 0xFFFF→0x0000), `col` += 1, `fetch` = 1 next cycle.
  - If `col` ≥ bytes: ignored; `addr` holds and `fetch` stays 0.
- `fetch` is 0 in every cycle not following an accepted `da0_rise`.
- Reset values:
  - `addr` 0x0000, `line_start` 0, `col` 0, `row_rep` 0, `fetch` 0.
  - `mode_q` = alpha.
  - `hsn`/`fsn` sync flops = 1; `da0` sync flops = 0.
- Reset mid-row or mid-frame aborts all state. The first `fsn_fall` after reset re-establishes the base address.

## Timing
- Input-to-output latency is 2 clocks. An input transition before edge k is captured in s1 at edge k, and `addr`/`row_rep`/`fetch` update at edge k+1.
- Input pulses must be at least 1 clock high and 1 clock low to be detected. Back-to-back `da0` rises 2 clocks apart are each accepted.
- `addr` is registered and stable for the full cycle. RAM may sample it in any cycle after `fetch`.
- `rst` overrides all events in the same cycle.

## Test plan
- Reset/frame start: assert `rst`, then `base`=7'h02 and pulse `fsn` → `addr`=0x0400 two clocks after the `fsn` fall, `row_rep`=0, `fetch`=0.
- gm6 linear:
  - 32 `da0` pulses → `addr`=0x0420 with 32 `fetch` strobes.
  - Then `hsn` pulse → `addr` stays 0x0420, `row_rep`=0.
  - 5 extra `da0` pulses before the `hsn` → ignored, `addr` remains 0x0420.
- gm3 repeat:
  - 16 `da0` pulses → 0x0410.
  - First `hsn` → `addr`=0x0400, `row_rep`=1.
  - 16 `da0` pulses then second `hsn` → `addr`=0x0410, `row_rep`=0.
- Alpha ÷12: 12 rows of 32 `da0` pulses plus `hsn` each → `row_rep` sequence 1…11, 0. `addr` is 0x0400 after each of the first 11 `hsn`, and 0x0420 after the 12th.
- Priority and wrap:
  - `fsn` and `hsn` falling in the same cycle → frame reload only.
  - `da0` rising with `hsn` falling → no increment.
  - `base`=7'h7F: 512 accepted fetches → `addr` wraps to 0x0000.
- Mode latch: change `gm` from 6 to 0 mid-frame → geometry stays gm6 until the next `fsn` fall, then becomes ÷3/16 bytes.
